// File: rtl/rv_pkg.sv
// Shared RV32 definitions for the program loader and its instruction packer.
// Holds the major opcodes (same values the core's main decoder consumes),
// the loader's request type codes and the loader state enumeration.
package rv_pkg;

  // Major opcodes, bits [6:0] of every RV32I instruction word
  localparam logic [6:0] R_TYPE = 7'b0110011;
  localparam logic [6:0] I_TYPE = 7'b0010011;
  localparam logic [6:0] S_TYPE = 7'b0100011;
  localparam logic [6:0] B_TYPE = 7'b1100011;
  localparam logic [6:0] J_TYPE = 7'b1101111;
  localparam logic [6:0] U_TYPE = 7'b0110111;

  // Request type codes carried on in_type; 6 and 7 are illegal
  localparam logic [2:0] TYPE_R = 3'd0;
  localparam logic [2:0] TYPE_I = 3'd1;
  localparam logic [2:0] TYPE_S = 3'd2;
  localparam logic [2:0] TYPE_B = 3'd3;
  localparam logic [2:0] TYPE_J = 3'd4;
  localparam logic [2:0] TYPE_U = 3'd5;

  // Loader session states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCEPT = 2'd1,
    ST_WRITE  = 2'd2,
    ST_DONE   = 2'd3
  } loader_state_e;

  // True for the six type codes the packer can encode
  function automatic logic is_legal_type(input logic [2:0] typ);
    is_legal_type = (typ <= TYPE_U);
  endfunction

endpackage

// File: rtl/rv_instr_packer.sv
// Purely combinational RV32I field-to-word encoder.
// Ports:
//   typ     - request type code (TYPE_R..TYPE_U, others illegal)
//   rd/rs1/rs2, funct3, funct7 - register and function fields
//   imm     - immediate: value for I/S, byte offset for B/J, full value for U
//   word    - packed 32-bit instruction (zero when illegal)
//   illegal - high when typ is not one of the six encodable types
module rv_instr_packer
  import rv_pkg::*;
(
  input  logic [2:0]  typ,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        illegal
);

  // Field placement per instruction format; B/J drop imm[0] (always even offsets)
  always_comb begin
    word    = 32'h0000_0000;
    illegal = 1'b0;
    case (typ)
      TYPE_R: word = {funct7, rs2, rs1, funct3, rd, R_TYPE};
      TYPE_I: word = {imm[11:0], rs1, funct3, rd, I_TYPE};
      TYPE_S: word = {imm[11:5], rs2, rs1, funct3, imm[4:0], S_TYPE};
      TYPE_B: word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], B_TYPE};
      TYPE_J: word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, J_TYPE};
      TYPE_U: word = {imm[31:12], rd, U_TYPE};
      default: begin
        word    = 32'h0000_0000;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_mem_loader.sv
// Program loader: takes instruction requests as separate fields over a
// valid/ready handshake, packs them into RV32I words and writes them to
// consecutive word addresses of instruction memory over a we/ack handshake.
// Ports:
//   clk, rst           - clock, asynchronous active-high reset
//   start, base_addr   - open a session at the word-aligned base address
//   in_valid/in_ready  - request handshake; in_type/in_rd/in_rs1/in_rs2/
//                        in_funct3/in_funct7/in_imm carry the fields
//   finish             - close the session after any pending write
//   mem_we/mem_addr/mem_wdata/mem_ack - memory write port
//   busy, done, err    - status: non-idle, end-of-session pulse, sticky error
//   word_count         - words written in the current session
module instr_mem_loader
  import rv_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int MAX_WORDS = 1024,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_type,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  input  logic              finish,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  word_count
);

  localparam logic [CNT_W-1:0]  MAX_CNT    = CNT_W'(MAX_WORDS);
  localparam logic [ADDR_W-1:0] ADDR_STEP  = ADDR_W'(3'd4);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(2'd3);

  loader_state_e     state_r;
  loader_state_e     next_state_s;

  logic [31:0]       pk_word_s;
  logic              pk_illegal_s;

  logic [ADDR_W-1:0] addr_r;
  logic [31:0]       wdata_r;
  logic [CNT_W-1:0]  count_r;
  logic              err_r;
  logic              finish_pend_r;

  logic [CNT_W-1:0]  count_inc_s;
  logic              max_hit_s;
  logic              end_req_s;

  logic              in_ready_s;
  logic              mem_we_s;
  logic              busy_s;
  logic              done_s;

  logic              in_ready_r;
  logic              mem_we_r;
  logic              busy_r;
  logic              done_r;

  rv_instr_packer u_packer (
    .typ     (in_type),
    .rd      (in_rd),
    .rs1     (in_rs1),
    .rs2     (in_rs2),
    .funct3  (in_funct3),
    .funct7  (in_funct7),
    .imm     (in_imm),
    .word    (pk_word_s),
    .illegal (pk_illegal_s)
  );

  // A finish seen in the ack cycle itself counts the same as a pending one
  assign count_inc_s = count_r + CNT_W'(1'b1);
  assign max_hit_s   = (count_inc_s == MAX_CNT);
  assign end_req_s   = finish_pend_r | finish;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          next_state_s = ST_ACCEPT;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_ACCEPT: begin
        if (in_valid && !pk_illegal_s) begin
          next_state_s = ST_WRITE;
        end else if (finish) begin
          // Covers finish alone and finish alongside a dropped illegal request
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_ACCEPT;
        end
      end
      ST_WRITE: begin
        if (mem_ack) begin
          if (end_req_s || max_hit_s) begin
            next_state_s = ST_DONE;
          end else begin
            next_state_s = ST_ACCEPT;
          end
        end else begin
          next_state_s = ST_WRITE;
        end
      end
      ST_DONE: begin
        next_state_s = ST_IDLE;
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Output decode from the next state so the registered copies line up with the state
  always_comb begin
    in_ready_s = (next_state_s == ST_ACCEPT);
    mem_we_s   = (next_state_s == ST_WRITE);
    busy_s     = (next_state_s != ST_IDLE);
    done_s     = (next_state_s == ST_DONE);
  end

  // Control output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready_r <= 1'b0;
      mem_we_r   <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      in_ready_r <= in_ready_s;
      mem_we_r   <= mem_we_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
    end
  end

  // Session datapath: write address, packed word, word counter, error and pending finish
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_r        <= '0;
      wdata_r       <= 32'h0000_0000;
      count_r       <= '0;
      err_r         <= 1'b0;
      finish_pend_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            addr_r        <= base_addr & ALIGN_MASK;
            count_r       <= '0;
            err_r         <= 1'b0;
            finish_pend_r <= 1'b0;
          end
        end
        ST_ACCEPT: begin
          if (in_valid) begin
            if (pk_illegal_s) begin
              err_r <= 1'b1;
            end else begin
              wdata_r <= pk_word_s;
              if (finish) begin
                finish_pend_r <= 1'b1;
              end
            end
          end
        end
        ST_WRITE: begin
          if (finish) begin
            finish_pend_r <= 1'b1;
          end
          if (mem_ack) begin
            addr_r  <= addr_r + ADDR_STEP;
            count_r <= count_inc_s;
            // Running out of room without an explicit finish is an error
            if (max_hit_s && !end_req_s) begin
              err_r <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          finish_pend_r <= 1'b0;
        end
        default: begin
          finish_pend_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_r;
  assign mem_we     = mem_we_r;
  assign mem_addr   = addr_r;
  assign mem_wdata  = wdata_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign err        = err_r;
  assign word_count = count_r;

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
- Program loader for the single-cycle RV32 core.
- Accepts instruction requests one at a time as separate fields (type, registers, functs, immediate) over a valid/ready handshake.
- Packs each request into a 32-bit RV32I word using the same opcodes the main decoder consumes: R 0110011, I 0010011, S 0100011, B 1100011, J 1101111, U 0110111.
- Writes the words to instruction memory at consecutive word addresses over a we/ack handshake. Used by the bench and boot path to fill instruction memory before the core runs.

Parameters:
- ADDR_W, 32, instruction memory address width.
- MAX_WORDS, 1024, maximum words written per session.
- CNT_W, 16, width of word_count.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a session; latches base_addr.
- base_addr  in  ADDR_W  first write address; bits [1:0] forced to 0.
- in_valid  in  1  request present.
- in_ready  out  1  loader accepts a request this cycle.
- in_type  in  3  instruction type: 0 R, 1 I, 2 S, 3 B, 4 J, 5 U, 6 and 7 illegal.
- in_rd, in_rs1, in_rs2  in  5 each  register fields.
- in_funct3  in  3  funct3 field.
- in_funct7  in  7  funct7 field.
- in_imm  in  32  immediate, byte offset (B/J) or full value (U).
- finish  in  1  end the session after any pending write.
- mem_we  out  1  write strobe, held until acknowledged.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  32  encoded instruction.
- mem_ack  in  1  memory accepted the write.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a session ends.
- err  out  1  sticky error flag; cleared at start.
- word_count  out  CNT_W  words written this session.

Behaviour:
- Reset (asynchronous): state IDLE. All outputs 0: in_ready, mem_we, mem_addr, mem_wdata, busy, done, err, word_count. finish_pend cleared.
- Reset during WRITE drops mem_we immediately.

States: IDLE, ACCEPT, WRITE, DONE.
- IDLE:
  - in_ready = 0.
  - start -> ACCEPT. Latches addr = {base_addr[ADDR_W-1:2], 2'b00}, word_count = 0, err = 0.
- ACCEPT:
  - in_ready = 1.
  - in_valid with a legal type: register the encoded word into mem_wdata -> WRITE.
  - in_valid with an illegal type: err = 1, request dropped, stay in ACCEPT.
  - finish without in_valid -> DONE.
  - in_valid and finish in the same cycle: the request is taken, finish_pend is set, and the state goes to DONE after the write completes.
- WRITE:
  - in_ready = 0. mem_we = 1, with mem_addr and mem_wdata stable until mem_ack.
  - finish arriving in WRITE sets finish_pend.
  - On mem_ack: mem_we = 0 next cycle, mem_addr += 4 (wraps modulo 2^ADDR_W), word_count += 1.
  - After the ack, go to DONE if finish_pend is set or word_count reaches MAX_WORDS; otherwise go to ACCEPT.
  - Ack latency is unbounded; the state stays in WRITE until mem_ack.
- DONE:
  - done = 1 for exactly one cycle, then IDLE.
  - err is set if the session ended on MAX_WORDS without finish.
- start outside IDLE is ignored.
- Latency: request accepted in cycle N gives mem_we = 1 in cycle N+1. With a same-cycle ack, the next in_ready is in cycle N+2.

Encoding (MSB to LSB):
- R: funct7 | rs2 | rs1 | f3 | rd | op.
- I: imm[11:0] | rs1 | f3 | rd | op.
- S: imm[11:5] | rs2 | rs1 | f3 | imm[4:0] | op.
- B: imm[12] | imm[10:5] | rs2 | rs1 | f3 | imm[4:1] | imm[11] | op.
- J: imm[20] | imm[10:1] | imm[11] | imm[19:12] | rd | op.
- U: imm[31:12] | rd | op.
- Unused fields and imm[0] for B/J are ignored.

Decomposition:
- Shared package rv_pkg holds:
  - opcode constants R_TYPE, I_TYPE, S_TYPE, B_TYPE, J_TYPE, U_TYPE (same values as the decoder);
  - type codes 0-5;
  - the loader state enum.
- Sub-module rv_instr_packer: purely combinational field-to-word encoder with an illegal-type flag. It is reused by the bench to generate expected words.

Test Plan:
- Single words: start, base_addr=0x100, then addi x1,x0,5 (I: rd=1, imm=5), then finish. Required: mem_wdata=0x00500093 at 0x100, word_count=1, one done pulse, err=0.
- Stream of five, ack always 1: add x3,x1,x2 / sw x2,8(x1) / beq x1,x2,-4 / jal x1,8 / lui x5,0x12345 from base 0x0. Required words:
  - 0x002081B3 at 0x0;
  - 0x0020A423 at 0x4;
  - 0xFE208EE3 at 0x8;
  - 0x008000EF at 0xC;
  - 0x123452B7 at 0x10;
  - word_count=5.
- Ack stall: mem_ack held low for 7 cycles. Required: mem_we, mem_addr and mem_wdata stable all 7 cycles, in_ready=0, finish asserted mid-stall ends the session right after the ack.
- Illegal type: in_type=6 between two legal requests. Required: err=1, addresses stay contiguous, word_count=2.
- Boundaries:
  - MAX_WORDS=4 with 6 requests offered: session ends after 4 writes, done pulses, err=1.
  - base_addr=0xFFFFFFFE: first write at 0xFFFFFFFC, second at 0x00000000.
- Reset mid-WRITE: rst asserted while mem_we=1. Required: all outputs 0 asynchronously, IDLE after release, the next start works normally.
